// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction-fetch unit.
package ifu_pkg;

  localparam int unsigned DEFAULT_ILEN     = 32;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  typedef enum logic [1:0] {BOOT, RUN, HALT} ifu_state_e;

  typedef struct packed {
    logic [63:0]             pc;
    logic [DEFAULT_ILEN-1:0] inst;
    logic                    err;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous DEPTH-entry FIFO with flush, occupancy count and wrap-around pointers.
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = ifu_entry_t,
  localparam int unsigned CW = $clog2(DEPTH + 1),
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  entry_t        push_data,
  input  logic          pop,
  output entry_t        head,
  output logic [CW-1:0] count
);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign head = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction-fetch unit: keeps up to DEPTH fetches in flight or buffered,
// flushes on redirect and discards responses belonging to the old stream.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = DEFAULT_ILEN,
  parameter int unsigned DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_err,
  output logic [CW-1:0]   occupancy
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
    logic            err;
  } entry_t;

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW:0]     credits_used;
  logic [XLEN-1:0] redirect_base;
  logic            req_fire, dropping, push, pop;
  entry_t          push_entry, head;
  logic            unused_redirect_lsb;

  // Credits cover both in-flight requests and buffered entries, so the queue never overflows.
  assign credits_used   = {1'b0, outstanding_q} + {1'b0, occupancy};
  assign imem_req_valid = (state_q == RUN) && (credits_used < (CW + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign dropping   = (drop_cnt_q != '0);
  assign push       = imem_rsp_valid && !dropping && !redirect_valid;
  assign pop        = out_valid && out_ready;
  assign push_entry = '{pc: rsp_pc_q, inst: imem_rsp_data, err: imem_rsp_err};

  assign redirect_base       = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  ifu_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (occupancy)
  );

  assign out_valid = (occupancy != '0);
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign out_err   = head.err;

  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    rsp_pc_d      = push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
    drop_cnt_d    = (imem_rsp_valid && dropping) ? drop_cnt_q - CW'(1) : drop_cnt_q;

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (push && imem_rsp_err) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase

    // Everything still owed by memory after this edge belongs to the old stream.
    if (redirect_valid) begin
      state_d    = RUN;
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

endmodule

// File: tb/tb_ifu_prefetch.sv
// Scoreboard bench for ifu_prefetch: directed scenarios against an in-order memory model.
module tb_ifu_prefetch;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned ILEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            redirect_valid = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [ILEN-1:0] imem_rsp_data = '0;
  logic            imem_rsp_err = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [ILEN-1:0] out_inst;
  logic [XLEN-1:0] out_pc;
  logic            out_err;
  logic [2:0]      occupancy;

  ifu_prefetch #(
    .XLEN     (XLEN),
    .ILEN     (ILEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_err        (out_err),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  int          checks = 0;
  int          errors = 0;
  int          consumed = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          ready_cfg = 1'b1;
  logic [63:0] err_addr = '1;
  exp_t        sb[$];
  pend_t       pend[$];
  logic [63:0] req_log[$];

  function automatic logic [31:0] inst_of(logic [63:0] a);
    return a[31:0] ^ 32'h1357_9bdf ^ {a[63:48], 16'h0000};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_push(logic [63:0] pc, logic err);
    sb.push_back('{pc, inst_of(pc), err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: fixed latency, in-order responses, one per cycle.
  always @(negedge clk) begin
    pend_t r;
    cyc++;
    if (!rst) begin
      pend.delete();
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b0;
    end else begin
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        r = pend.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = inst_of(r.addr);
        imem_rsp_err   = (r.addr == err_addr);
      end else begin
        imem_rsp_valid = 1'b0;
      end
      imem_req_ready = ready_cfg;
      if (imem_req_valid && ready_cfg) begin
        pend.push_back('{imem_req_addr, cyc + lat});
        req_log.push_back(imem_req_addr);
      end
    end
  end

  // Monitor: compare every accepted output against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst && occupancy > 3'(DEPTH)) begin
      errors++;
      $display("FAIL overflow: occupancy %0d exceeds %0d", occupancy, DEPTH);
    end
    if (rst && out_valid && out_ready) begin
      consumed++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %h, no entry expected", out_pc);
      end else begin
        e = sb.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_inst", {32'h0, out_inst}, {32'h0, e.inst});
        chk("out_err", {63'h0, out_err}, {63'h0, e.err});
      end
    end
  end

  task automatic wait_consumed(int target, string name);
    int n = 0;
    while (consumed < target && n < 400) begin
      step();
      n++;
    end
    if (consumed < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: consumed %0d, required %0d", name, consumed, target);
    end
  endtask

  // Leaves the bench at posedge+#1 of the edge just before the BOOT cycle.
  task automatic do_reset(bit ordy);
    rst = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    req_log.delete();
    out_ready = ordy;
    rst = 1'b1;
  endtask

  task automatic chk_reset_values(string tag);
    chk({tag, "_req_valid"}, {63'h0, imem_req_valid}, 64'd0);
    chk({tag, "_out_valid"}, {63'h0, out_valid}, 64'd0);
    chk({tag, "_out_err"}, {63'h0, out_err}, 64'd0);
    chk({tag, "_occupancy"}, {61'h0, occupancy}, 64'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RST_PC);
    chk({tag, "_out_inst"}, {32'h0, out_inst}, 64'd0);
    chk({tag, "_out_pc"}, out_pc, 64'd0);
  endtask

  initial begin
    int base;
    int n;

    // Reset values, startup latency and steady throughput
    lat = 1; ready_cfg = 1'b1; err_addr = '1;
    step();
    chk_reset_values("rst0");
    do_reset(1'b1);
    base = consumed;
    for (int i = 0; i < 8; i++) exp_push(RST_PC + 64'(4 * i), 1'b0);
    step();
    chk("boot_req_valid", {63'h0, imem_req_valid}, 64'd1);
    chk("boot_req_addr", imem_req_addr, 64'h8000_0000);
    chk("boot_out_valid", {63'h0, out_valid}, 64'd0);
    step();
    chk("second_req_addr", imem_req_addr, 64'h8000_0004);
    chk("early_out_valid", {63'h0, out_valid}, 64'd0);
    step();
    chk("first_out_valid", {63'h0, out_valid}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_out_valid", {63'h0, out_valid}, 64'd1);
    end
    chk("req_log0", req_log[0], 64'h8000_0000);
    chk("req_log1", req_log[1], 64'h8000_0004);
    chk("req_log2", req_log[2], 64'h8000_0008);
    wait_consumed(base + 8, "stream");
    out_ready = 1'b0;

    // Backpressure with latency 2: credits cap issue at DEPTH
    lat = 2;
    do_reset(1'b0);
    base = consumed;
    repeat (15) step();
    chk("bp_req_count", 64'(req_log.size()), 64'd4);
    chk("bp_occupancy", {61'h0, occupancy}, 64'd4);
    chk("bp_req_valid", {63'h0, imem_req_valid}, 64'd0);
    chk("bp_out_valid", {63'h0, out_valid}, 64'd1);
    for (int i = 0; i < 8; i++) exp_push(RST_PC + 64'(4 * i), 1'b0);
    out_ready = 1'b1;
    wait_consumed(base + 8, "bp");
    out_ready = 1'b0;

    // Redirect with three requests outstanding; old responses dropped
    lat = 6;
    do_reset(1'b1);
    base = consumed;
    n = 0;
    while (req_log.size() < 3 && n < 50) begin
      step();
      n++;
    end
    chk("rd3_req_count", 64'(req_log.size()), 64'd3);
    ready_cfg = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_1002;
    step();
    redirect_valid = 1'b0;
    ready_cfg = 1'b1;
    chk("rd3_occupancy", {61'h0, occupancy}, 64'd0);
    chk("rd3_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rd3_req_addr", imem_req_addr, 64'h8000_1000);
    for (int i = 0; i < 4; i++) exp_push(64'h8000_1000 + 64'(4 * i), 1'b0);
    wait_consumed(base + 4, "rd3");
    out_ready = 1'b0;

    // Redirect coinciding with a request fire and a response
    lat = 1;
    do_reset(1'b1);
    base = consumed;
    for (int i = 0; i < 5; i++) exp_push(RST_PC + 64'(4 * i), 1'b0);
    for (int i = 0; i < 4; i++) exp_push(64'h8000_2000 + 64'(4 * i), 1'b0);
    wait_consumed(base + 4, "rdc_pre");
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_2000;
    step();
    redirect_valid = 1'b0;
    chk("rdc_occupancy", {61'h0, occupancy}, 64'd0);
    chk("rdc_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rdc_req_addr", imem_req_addr, 64'h8000_2000);
    step();
    chk("rdc_stale_dropped", {63'h0, out_valid}, 64'd0);
    step();
    chk("rdc_new_valid", {63'h0, out_valid}, 64'd1);
    wait_consumed(base + 9, "rdc");
    out_ready = 1'b0;

    // Access fault halts fetch; redirect resumes
    err_addr = 64'h8000_0008;
    do_reset(1'b1);
    base = consumed;
    exp_push(64'h8000_0000, 1'b0);
    exp_push(64'h8000_0004, 1'b0);
    exp_push(64'h8000_0008, 1'b1);
    exp_push(64'h8000_000c, 1'b0);
    wait_consumed(base + 4, "err");
    step();
    step();
    chk("halt_req_valid", {63'h0, imem_req_valid}, 64'd0);
    chk("halt_req_count", 64'(req_log.size()), 64'd4);
    for (int i = 0; i < 3; i++) exp_push(64'h8000_0100 + 64'(4 * i), 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("resume_req_valid", {63'h0, imem_req_valid}, 64'd1);
    chk("resume_req_addr", imem_req_addr, 64'h8000_0100);
    wait_consumed(base + 7, "resume");
    out_ready = 1'b0;
    err_addr = '1;

    // PC wrap at the top of the address space, then async reset mid-stream
    do_reset(1'b1);
    base = consumed;
    exp_push(64'hffff_ffff_ffff_fffc, 1'b0);
    for (int i = 0; i < 3; i++) exp_push(64'(4 * i), 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 64'hffff_ffff_ffff_fffc;
    step();
    redirect_valid = 1'b0;
    chk("wrap_req_addr0", imem_req_addr, 64'hffff_ffff_ffff_fffc);
    step();
    chk("wrap_req_addr1", imem_req_addr, 64'h0);
    wait_consumed(base + 4, "wrap");
    out_ready = 1'b0;
    repeat (6) step();
    chk("prerst_occupancy", {61'h0, occupancy}, 64'd4);
    rst = 1'b0;
    #2;
    chk_reset_values("midrst");
    step();
    chk("sb_final", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
